// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencing controller: boot, branch/exception redirect, stall watchdog, flush timing.
// Optional build macro FETCH_CTRL_PERF_EN adds saturating stall/flush performance counters.
module fetch_ctrl #(
  parameter int unsigned PC_W      = 5,
  parameter int unsigned BOOT_CYC  = 2,
  parameter int unsigned FLUSH_CYC = 2,
  parameter int unsigned STALL_MAX = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_req,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic            exc_req,
  input  logic            exc_clear,
  input  logic [PC_W-1:0] exc_ret_pc,
  output logic            fetch_en,
  output logic            fetch_jump,
  output logic [PC_W-1:0] fetch_jump_pc,
  output logic            fetch_trap,
  output logic            flush,
  output logic            stall_timeout,
  output logic [2:0]      state_o
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [15:0]     perf_stall_cnt,
  output logic [15:0]     perf_flush_cnt
`endif
);

  localparam logic [2:0] S_BOOT  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_STALL = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_TRAP  = 3'd4;

  localparam int unsigned BOOT_W  = $clog2(BOOT_CYC + 1);
  localparam int unsigned FLUSH_W = $clog2(FLUSH_CYC + 1);
  localparam int unsigned STALL_W = $clog2(STALL_MAX + 1);

  logic [2:0]         r_state;
  logic [BOOT_W-1:0]  r_boot_cnt;
  logic [FLUSH_W-1:0] r_flush_cnt;
  logic [STALL_W-1:0] r_stall_cnt;

  logic [2:0]         w_state_nxt;
  logic [BOOT_W-1:0]  w_boot_nxt;
  logic [FLUSH_W-1:0] w_flush_nxt;
  logic [STALL_W-1:0] w_stall_nxt;

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_BOOT;
      r_boot_cnt  <= '0;
      r_flush_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_boot_cnt  <= w_boot_nxt;
      r_flush_cnt <= w_flush_nxt;
      r_stall_cnt <= w_stall_nxt;
    end
  end

  // Next-state and combinational outputs; counters read zero outside their own state
  always_comb begin
    w_state_nxt   = r_state;
    w_boot_nxt    = '0;
    w_flush_nxt   = '0;
    w_stall_nxt   = '0;
    fetch_en      = 1'b0;
    fetch_jump    = 1'b0;
    fetch_jump_pc = '0;
    fetch_trap    = 1'b0;
    flush         = 1'b1;
    stall_timeout = 1'b0;

    case (r_state)
      S_BOOT: begin
        if (r_boot_cnt == BOOT_W'(BOOT_CYC - 1)) begin
          fetch_en    = 1'b1;
          fetch_jump  = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_boot_nxt = r_boot_cnt + BOOT_W'(1);
        end
      end

      S_RUN: begin
        fetch_en = 1'b1;
        flush    = 1'b0;
        if (exc_req) begin
          fetch_en    = 1'b0;
          flush       = 1'b1;
          w_state_nxt = S_TRAP;
        end else if (br_taken) begin
          fetch_jump    = 1'b1;
          fetch_jump_pc = br_target;
          flush         = 1'b1;
          w_state_nxt   = S_FLUSH;
        end else if (stall_req) begin
          fetch_en    = 1'b0;
          w_stall_nxt = STALL_W'(1);
          w_state_nxt = S_STALL;
        end
      end

      S_STALL: begin
        flush = 1'b0;
        if (exc_req) begin
          flush       = 1'b1;
          w_state_nxt = S_TRAP;
        end else if (br_taken) begin
          fetch_en      = 1'b1;
          fetch_jump    = 1'b1;
          fetch_jump_pc = br_target;
          flush         = 1'b1;
          w_state_nxt   = S_FLUSH;
        end else if (!stall_req) begin
          fetch_en    = 1'b1;
          w_state_nxt = S_RUN;
        end else if (r_stall_cnt < STALL_W'(STALL_MAX)) begin
          w_stall_nxt = r_stall_cnt + STALL_W'(1);
        end else begin
          stall_timeout = 1'b1;
          flush         = 1'b1;
          w_state_nxt   = S_TRAP;
        end
      end

      S_FLUSH: begin
        fetch_en = 1'b1;
        if (exc_req) begin
          fetch_en    = 1'b0;
          w_state_nxt = S_TRAP;
        end else if (r_flush_cnt == FLUSH_W'(FLUSH_CYC - 1)) begin
          w_state_nxt = S_RUN;
        end else begin
          w_flush_nxt = r_flush_cnt + FLUSH_W'(1);
        end
      end

      S_TRAP: begin
        fetch_trap = 1'b1;
        if (exc_clear) begin
          fetch_trap    = 1'b0;
          fetch_en      = 1'b1;
          fetch_jump    = 1'b1;
          fetch_jump_pc = exc_ret_pc;
          w_state_nxt   = S_FLUSH;
        end
      end

      default: begin
        w_state_nxt = S_BOOT;
      end
    endcase

    // Hold reset output values while rst_n is low, independent of BOOT_CYC
    if (!rst_n) begin
      fetch_en      = 1'b0;
      fetch_jump    = 1'b0;
      fetch_jump_pc = '0;
      fetch_trap    = 1'b0;
      flush         = 1'b1;
      stall_timeout = 1'b0;
    end
  end

  assign state_o = r_state;

`ifdef FETCH_CTRL_PERF_EN
  logic [15:0] r_perf_stall;
  logic [15:0] r_perf_flush;
  logic        w_perf_stall_inc;
  logic        w_perf_flush_inc;

  assign w_perf_stall_inc = ((r_state == S_RUN) || (r_state == S_STALL)) && !fetch_en;
  assign w_perf_flush_inc = flush && (r_state != S_BOOT);

  // Saturating performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if (w_perf_stall_inc && (r_perf_stall != 16'hFFFF)) r_perf_stall <= r_perf_stall + 16'd1;
      if (w_perf_flush_inc && (r_perf_flush != 16'hFFFF)) r_perf_flush <= r_perf_flush + 16'd1;
    end
  end

  assign perf_stall_cnt = r_perf_stall;
  assign perf_flush_cnt = r_perf_flush;
`endif

  // Output invariants
  a_trap_no_en : assert property (@(posedge clk) disable iff (!rst_n) fetch_trap |-> !fetch_en);
  a_jump_en    : assert property (@(posedge clk) disable iff (!rst_n) fetch_jump |-> fetch_en);
  a_pc_zero    : assert property (@(posedge clk) disable iff (!rst_n) !fetch_jump |-> (fetch_jump_pc == '0));
  a_to_pulse   : assert property (@(posedge clk) disable iff (!rst_n) stall_timeout |=> !stall_timeout);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Table-driven self-checking bench for fetch_ctrl with an expected-output scoreboard queue.
module tb_fetch_ctrl;
  localparam int unsigned PC_W = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            stall_req;
  logic            br_taken;
  logic [PC_W-1:0] br_target;
  logic            exc_req;
  logic            exc_clear;
  logic [PC_W-1:0] exc_ret_pc;
  logic            fetch_en;
  logic            fetch_jump;
  logic [PC_W-1:0] fetch_jump_pc;
  logic            fetch_trap;
  logic            flush;
  logic            stall_timeout;
  logic [2:0]      state_o;
`ifdef FETCH_CTRL_PERF_EN
  logic [15:0]     perf_stall_cnt;
  logic [15:0]     perf_flush_cnt;
`endif

  fetch_ctrl #(.PC_W(PC_W), .BOOT_CYC(2), .FLUSH_CYC(2), .STALL_MAX(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_req    (stall_req),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .exc_req      (exc_req),
    .exc_clear    (exc_clear),
    .exc_ret_pc   (exc_ret_pc),
    .fetch_en     (fetch_en),
    .fetch_jump   (fetch_jump),
    .fetch_jump_pc(fetch_jump_pc),
    .fetch_trap   (fetch_trap),
    .flush        (flush),
    .stall_timeout(stall_timeout),
    .state_o      (state_o)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            en;
    logic            jump;
    logic [PC_W-1:0] pc;
    logic            trap;
    logic            fl;
    logic            to;
    logic [2:0]      st;
  } outs_t;

  typedef struct {
    string           name;
    logic            stall;
    logic            br;
    logic [PC_W-1:0] tgt;
    logic            exc;
    logic            clr;
    logic [PC_W-1:0] ret;
    outs_t           exp;
  } vec_t;

  vec_t  vecs[$];
  outs_t exp_q[$];
  int    n_vec = 0;
  int    n_bad = 0;

  function automatic outs_t o(logic en, logic jump, logic [PC_W-1:0] pc, logic trap,
                              logic fl, logic to, logic [2:0] st);
    outs_t r;
    r.en = en; r.jump = jump; r.pc = pc; r.trap = trap; r.fl = fl; r.to = to; r.st = st;
    return r;
  endfunction

  function automatic void add(string nm, logic stall, logic br, logic [PC_W-1:0] tgt,
                              logic exc, logic clr, logic [PC_W-1:0] ret, outs_t e);
    vec_t v;
    v.name = nm; v.stall = stall; v.br = br; v.tgt = tgt;
    v.exc = exc; v.clr = clr; v.ret = ret; v.exp = e;
    vecs.push_back(v);
  endfunction

  task automatic drive(logic stall, logic br, logic [PC_W-1:0] tgt,
                       logic exc, logic clr, logic [PC_W-1:0] ret);
    stall_req = stall; br_taken = br; br_target = tgt;
    exc_req = exc; exc_clear = clr; exc_ret_pc = ret;
  endtask

  task automatic check(string nm);
    outs_t got;
    outs_t want;
    got = o(fetch_en, fetch_jump, fetch_jump_pc, fetch_trap, flush, stall_timeout, state_o);
    if (exp_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      want = exp_q.pop_front();
      n_vec++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL %s: got en=%b jmp=%b pc=%0d trap=%b fl=%b to=%b st=%0d, want en=%b jmp=%b pc=%0d trap=%b fl=%b to=%b st=%0d",
                 nm, got.en, got.jump, got.pc, got.trap, got.fl, got.to, got.st,
                 want.en, want.jump, want.pc, want.trap, want.fl, want.to, want.st);
      end
    end
  endtask

  outs_t BOOT1, BOOT2, RUNI, FLSH, STL, TRP, RSTV;

  initial begin
    BOOT1 = o(1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 3'd0);
    BOOT2 = o(1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 3'd0);
    RUNI  = o(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd1);
    FLSH  = o(1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 3'd3);
    STL   = o(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd2);
    TRP   = o(1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 3'd4);
    RSTV  = BOOT1;

    // Boot, with every input active to show it is ignored
    add("boot1",         1, 1, 5'd9,  1, 0, 5'd0,  BOOT1);
    add("boot2",         1, 1, 5'd9,  1, 1, 5'd7,  BOOT2);
    add("run_idle",      0, 0, 5'd0,  0, 0, 5'd0,  RUNI);
    // Branch redirect, wrong-path sources ignored during flush
    add("br_redirect",   0, 1, 5'd22, 0, 0, 5'd0,  o(1, 1, 5'd22, 0, 1, 0, 3'd1));
    add("flush1_br_ign", 1, 1, 5'd7,  0, 0, 5'd0,  FLSH);
    add("flush2_br_ign", 1, 1, 5'd7,  0, 0, 5'd0,  FLSH);
    add("run_post_br",   0, 0, 5'd0,  0, 0, 5'd0,  RUNI);
    // Three-cycle stall
    add("stall_f1",      1, 0, 5'd0,  0, 0, 5'd0,  o(0, 0, 5'd0, 0, 0, 0, 3'd1));
    add("stall_f2",      1, 0, 5'd0,  0, 0, 5'd0,  STL);
    add("stall_f3",      1, 0, 5'd0,  0, 0, 5'd0,  STL);
    add("stall_drop",    0, 0, 5'd0,  0, 0, 5'd0,  o(1, 0, 5'd0, 0, 0, 0, 3'd2));
    add("run_post_stl",  0, 0, 5'd0,  0, 0, 5'd0,  RUNI);
    // Watchdog: stall held 20 cycles
    add("wd_f1",         1, 0, 5'd0,  0, 0, 5'd0,  o(0, 0, 5'd0, 0, 0, 0, 3'd1));
    for (int k = 2; k <= 8; k++) add($sformatf("wd_f%0d", k), 1, 0, 5'd0, 0, 0, 5'd0, STL);
    add("wd_timeout",    1, 0, 5'd0,  0, 0, 5'd0,  o(0, 0, 5'd0, 0, 1, 1, 3'd2));
    for (int k = 10; k <= 20; k++) add($sformatf("wd_trap%0d", k), 1, 0, 5'd0, 0, 0, 5'd0, TRP);
    add("trap_clear12",  0, 0, 5'd0,  0, 1, 5'd12, o(1, 1, 5'd12, 0, 1, 0, 3'd4));
    add("wd_flush1",     0, 0, 5'd0,  0, 0, 5'd0,  FLSH);
    add("wd_flush2",     0, 0, 5'd0,  0, 0, 5'd0,  FLSH);
    add("wd_run",        0, 0, 5'd0,  0, 0, 5'd0,  RUNI);
    // Priority, trap input masking, exception during flush
    add("prio_all",      1, 1, 5'd30, 1, 0, 5'd0,  o(0, 0, 5'd0, 0, 1, 0, 3'd1));
    add("trap_ign",      1, 1, 5'd5,  1, 0, 5'd9,  TRP);
    add("trap_clear3",   0, 0, 5'd0,  0, 1, 5'd3,  o(1, 1, 5'd3, 0, 1, 0, 3'd4));
    add("flush_exc",     1, 1, 5'd4,  1, 0, 5'd0,  o(0, 0, 5'd0, 0, 1, 0, 3'd3));
    add("trap_again",    0, 0, 5'd0,  0, 0, 5'd0,  TRP);
    add("trap_clear0",   0, 0, 5'd0,  0, 1, 5'd0,  o(1, 1, 5'd0, 0, 1, 0, 3'd4));
    add("fl_a1",         0, 0, 5'd0,  0, 0, 5'd0,  FLSH);
    add("fl_a2",         0, 0, 5'd0,  0, 0, 5'd0,  FLSH);
    add("run_a",         0, 0, 5'd0,  0, 0, 5'd0,  RUNI);
    // Branch out of STALL
    add("stl_pre_br",    1, 0, 5'd0,  0, 0, 5'd0,  o(0, 0, 5'd0, 0, 0, 0, 3'd1));
    add("stall_br",      1, 1, 5'd17, 0, 0, 5'd0,  o(1, 1, 5'd17, 0, 1, 0, 3'd2));
    add("fl_b1",         1, 0, 5'd0,  0, 0, 5'd0,  FLSH);
    add("fl_b2",         0, 0, 5'd0,  0, 0, 5'd0,  FLSH);
    add("run_b",         0, 0, 5'd0,  0, 0, 5'd0,  RUNI);
    // Exception out of STALL
    add("stl_pre_exc",   1, 0, 5'd0,  0, 0, 5'd0,  o(0, 0, 5'd0, 0, 0, 0, 3'd1));
    add("stall_exc",     1, 0, 5'd0,  1, 0, 5'd0,  o(0, 0, 5'd0, 0, 1, 0, 3'd2));
    add("trap_c",        0, 0, 5'd0,  0, 0, 5'd0,  TRP);
    add("trap_clear31",  0, 0, 5'd0,  0, 1, 5'd31, o(1, 1, 5'd31, 0, 1, 0, 3'd4));
    add("fl_c1",         0, 0, 5'd0,  0, 0, 5'd0,  FLSH);
    add("fl_c2",         0, 0, 5'd0,  0, 0, 5'd0,  FLSH);
    add("run_c",         0, 0, 5'd0,  0, 0, 5'd0,  RUNI);

    rst_n = 1'b0;
    drive(0, 0, 5'd0, 0, 0, 5'd0);
    @(negedge clk);
    #2;
    exp_q.push_back(RSTV);
    check("reset");

    @(negedge clk);
    rst_n = 1'b1;
    foreach (vecs[i]) begin
      drive(vecs[i].stall, vecs[i].br, vecs[i].tgt, vecs[i].exc, vecs[i].clr, vecs[i].ret);
      exp_q.push_back(vecs[i].exp);
      #2;
      check(vecs[i].name);
      @(negedge clk);
    end

    // Asynchronous reset between edges in the middle of FLUSH
    drive(0, 1, 5'd22, 0, 0, 5'd0);
    exp_q.push_back(o(1, 1, 5'd22, 0, 1, 0, 3'd1));
    #2;
    check("ar_branch");
    @(negedge clk);
    drive(0, 0, 5'd0, 0, 0, 5'd0);
    exp_q.push_back(FLSH);
    #2;
    check("ar_flush1");
    #1;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(RSTV);
    check("ar_reset");
`ifdef FETCH_CTRL_PERF_EN
    n_vec++;
    if ((perf_stall_cnt !== 16'd0) || (perf_flush_cnt !== 16'd0)) begin
      n_bad++;
      $display("FAIL ar_perf: got stall=%0d flush=%0d, want 0 0", perf_stall_cnt, perf_flush_cnt);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(BOOT1);
    #2;
    check("ar_boot1");
    @(negedge clk);
    exp_q.push_back(BOOT2);
    #2;
    check("ar_boot2");
    @(negedge clk);
    exp_q.push_back(RUNI);
    #2;
    check("ar_run");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequencing controller for the 5-bit-PC fetch stage. Drives its enable, jump, jump-target and trap-hold inputs.
- Arbitrates three sources of control: exception requests, taken branches resolved in execute, and stall requests from decode hazard detection.
- Generates a flush strobe that kills wrong-path instructions downstream.
- Contains boot sequencing, a stall watchdog and post-redirect flush timing.

Parameters:
PC_W, 5, width of PC and jump target
BOOT_CYC, 2, cycles after reset release before fetch starts (>=1)
FLUSH_CYC, 2, flush cycles following a redirect cycle (>=1)
STALL_MAX, 8, max consecutive frozen cycles before watchdog trap (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
stall_req  in  1  decode hazard, freeze fetch
br_taken  in  1  execute resolved a taken branch this cycle
br_target  in  PC_W  branch target, valid with br_taken
exc_req  in  1  exception raised, park fetch
exc_clear  in  1  exception handled, resume
exc_ret_pc  in  PC_W  resume PC, valid with exc_clear
fetch_en  out  1  to fetch enable
fetch_jump  out  1  to fetch jump
fetch_jump_pc  out  PC_W  to fetch jumpPC; 0 whenever fetch_jump=0
fetch_trap  out  1  to fetch trapPC (PC hold)
flush  out  1  invalidate instruction register contents downstream
stall_timeout  out  1  one-cycle watchdog pulse
state_o  out  3  BOOT=0, RUN=1, STALL=2, FLUSH=3, TRAP=4

Behaviour:
- Outputs are combinational from the current state and inputs. State and counters are registered. Redirects therefore take effect at the same clock edge as the request.
- Reset (rst_n=0, async, any time including mid-operation):
  - state=BOOT, all counters 0.
  - Outputs: fetch_en=0, fetch_jump=0, fetch_jump_pc=0, fetch_trap=0, flush=1, stall_timeout=0.
- BOOT:
  - Cycles 1..BOOT_CYC-1: fetch_en=0, flush=1.
  - Cycle BOOT_CYC: fetch_en=1, fetch_jump=1, fetch_jump_pc=0, flush=1; next state RUN. This forces PC=0 deterministically.
  - All inputs are ignored in BOOT.
- RUN:
  - Default: fetch_en=1, flush=0.
  - Priority: exc_req > br_taken > stall_req.
  - exc_req: fetch_en=0, flush=1; next TRAP.
  - br_taken: fetch_en=1, fetch_jump=1, fetch_jump_pc=br_target, flush=1; next FLUSH, flush counter=0.
  - stall_req: fetch_en=0. This cycle is frozen cycle 1; next STALL, stall count=1.
- STALL (same priority order):
  - exc_req: fetch_en=0, flush=1; next TRAP.
  - br_taken: redirect exactly as in RUN; next FLUSH.
  - stall_req=0: fetch_en=1; next RUN.
  - stall_req=1 and count<STALL_MAX: fetch_en=0, count+1.
  - stall_req=1 and count==STALL_MAX: fetch_en=0, stall_timeout=1, flush=1; next TRAP.
- FLUSH:
  - fetch_en=1, flush=1 for FLUSH_CYC cycles, then RUN.
  - br_taken and stall_req are ignored (wrong-path sources).
  - exc_req: fetch_en=0; next TRAP.
- TRAP:
  - fetch_en=0, fetch_trap=1, flush=1. All inputs except exc_clear are ignored.
  - exc_clear: fetch_trap=0, fetch_en=1, fetch_jump=1, fetch_jump_pc=exc_ret_pc; next FLUSH, flush counter=0.
- Invariants:
  - fetch_trap=1 implies fetch_en=0.
  - fetch_jump=1 implies fetch_en=1.
  - stall_timeout is high for at most 1 cycle per event.
  - Illegal state encodings recover to BOOT on the next edge.
- The stall counter is PC-independent, wide enough for STALL_MAX, and never wraps.

Optional Feature:
FETCH_CTRL_PERF_EN
- Defined: adds outputs perf_stall_cnt and perf_flush_cnt, each 16 bits, reset 0, saturating at 0xFFFF.
  - perf_stall_cnt increments on each RUN/STALL cycle with fetch_en=0.
  - perf_flush_cnt increments on each cycle with flush=1 outside BOOT.
- Undefined: the ports and counters are absent and all other behaviour is identical.

Test Plan:
- Boot: release rst_n with BOOT_CYC=2 -> cycle 1 fetch_en=0, flush=1; cycle 2 fetch_jump=1, fetch_jump_pc=0, fetch_en=1; cycle 3 state_o=1, flush=0.
- Branch: in RUN pulse br_taken with br_target=22 -> same cycle fetch_jump=1, fetch_jump_pc=22, flush=1. Next 2 cycles flush=1, and a br_taken injected during them is ignored; then RUN.
- Stall: hold stall_req 3 cycles then drop -> fetch_en=0 for exactly 3 cycles, state_o=2 on cycles 2-3, fetch_en=1 the cycle stall_req drops, no stall_timeout.
- Watchdog: STALL_MAX=8, stall_req held 20 cycles -> stall_timeout=1 on frozen cycle 9 only, then TRAP with fetch_trap=1. Then exc_clear with exc_ret_pc=12 -> fetch_jump_pc=12, FLUSH, RUN.
- Priority: exc_req, br_taken and stall_req asserted together in RUN -> fetch_en=0, fetch_jump=0, next state TRAP.
- Async reset: assert rst_n=0 mid-FLUSH, between clock edges -> outputs go to reset values immediately; with FETCH_CTRL_PERF_EN defined, both perf counters read 0.
